pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/run controller: HALT/RUN/STEP FSM, stall/flush generation, saturating event counters.
// Optional feature: define PIPE_CTRL_FWD_EN when external forwarding exists (stall on load-use only).
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        step,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_jump,
   input  logic        ex_memread,
   input  logic        ex_regwrite,
   input  logic [4:0]  ex_wa,
   input  logic        mem_regwrite,
   input  logic [4:0]  mem_wa,
   input  logic        wb_regwrite,
   input  logic [4:0]  wb_wa,
   input  logic        mem_pcsrc,
   output logic        pc_we,
   output logic        if_id_we,
   output logic        pipe_we,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_active;
   logic             w_stall;
   logic             w_stall_evt;
   logic             w_flush_evt;

   // Destination in a later stage collides with a source read by the ID instruction.
   function automatic logic hazard_hit(input logic       we,
                                       input logic [4:0] dest,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
      return we && (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
   endfunction

`ifdef PIPE_CTRL_FWD_EN
   logic w_unused_fwd;
   assign w_unused_fwd = ^{mem_regwrite, mem_wa, wb_regwrite, wb_wa};
   assign w_stall = ex_memread && hazard_hit(ex_regwrite, ex_wa, id_rs, id_rt, id_uses_rt);
`else
   logic w_unused_load;
   assign w_unused_load = ex_memread;
   assign w_stall = hazard_hit(ex_regwrite,  ex_wa,  id_rs, id_rt, id_uses_rt)
                 || hazard_hit(mem_regwrite, mem_wa, id_rs, id_rt, id_uses_rt)
                 || hazard_hit(wb_regwrite,  wb_wa,  id_rs, id_rt, id_uses_rt);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_HALT;
      else      r_state <= w_state_nxt;
   end

   // Next state and control outputs; priority is taken branch > data stall > jump.
   always_comb begin
      w_state_nxt  = r_state;
      w_active     = 1'b0;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      pipe_we      = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      w_stall_evt  = 1'b0;
      w_flush_evt  = 1'b0;

      case (r_state)
         ST_HALT: begin
            if (run)       w_state_nxt = ST_RUN;
            else if (step) w_state_nxt = ST_STEP;
         end
         ST_RUN: begin
            w_active = 1'b1;
            if (!run) w_state_nxt = ST_HALT;
         end
         ST_STEP: begin
            w_active    = 1'b1;
            w_state_nxt = run ? ST_RUN : ST_HALT;
         end
         default: w_state_nxt = ST_HALT;
      endcase

      if (w_active) begin
         if (mem_pcsrc) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            pipe_we      = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            w_flush_evt  = 1'b1;
         end else if (w_stall) begin
            pipe_we      = 1'b1;
            id_ex_flush  = 1'b1;
            w_stall_evt  = 1'b1;
         end else begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            pipe_we      = 1'b1;
            if (id_jump) begin
               if_id_flush = 1'b1;
               w_flush_evt = 1'b1;
            end
         end
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_evt && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign state     = r_state;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
